// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use/branch hazards and data-memory wait/timeout FSM.
// Optional stall performance counter is built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
    input  logic [1:0]                ResultSrcE_i,
    input  logic                      RegWriteM_i,
    input  logic                      RegWriteW_i,
    input  logic                      PCSrcE_i,
    input  logic                      MemReqM_i,
    input  logic                      MemReadyM_i,
    output logic [1:0]                ForwardAE_o,
    output logic [1:0]                ForwardBE_o,
    output logic                      StallF_o,
    output logic                      StallD_o,
    output logic                      StallE_o,
    output logic                      StallM_o,
    output logic                      FlushD_o,
    output logic                      FlushE_o,
    output logic                      FlushW_o,
    output logic                      MemTimeout_o,
    output logic [CNT_WIDTH-1:0]      StallCount_o
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};

    state_t            state_r;
    logic [WAIT_W-1:0] waitCnt_r;

    logic loadUse_s;
    logic memStall_s;
    logic stallF_s;
    logic stallD_s;
    logic stallE_s;
    logic stallM_s;
    logic flushD_s;
    logic flushE_s;
    logic flushW_s;

    // M-stage result wins over W-stage; register 0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwdSel(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic                      regWriteM,
        input logic [REG_ADDR_WIDTH-1:0] rdM,
        input logic                      regWriteW,
        input logic [REG_ADDR_WIDTH-1:0] rdW
    );
        logic [1:0] sel;
        if (regWriteM && (rdM != REG_ZERO) && (rdM == rs)) begin
            sel = 2'b10;
        end else if (regWriteW && (rdW != REG_ZERO) && (rdW == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign ForwardAE_o = fwdSel(Rs1E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);
    assign ForwardBE_o = fwdSel(Rs2E_i, RegWriteM_i, RdM_i, RegWriteW_i, RdW_i);

    // Memory wait/timeout state machine and its wait counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r   <= RUN;
            waitCnt_r <= {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (MemReqM_i && !MemReadyM_i) begin
                        state_r   <= MEM_WAIT;
                        waitCnt_r <= {WAIT_W{1'b0}};
                    end else begin
                        state_r   <= RUN;
                    end
                end
                MEM_WAIT: begin
                    if (MemReadyM_i) begin
                        state_r <= RUN;
                    end else if (waitCnt_r == WAIT_LAST) begin
                        state_r <= ERROR;
                    end else begin
                        waitCnt_r <= waitCnt_r + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    state_r <= ERROR;
                end
                default: begin
                    state_r   <= RUN;
                    waitCnt_r <= {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    // Stall/flush decode; an unacknowledged request in RUN stalls in the same cycle it is seen.
    always_comb begin
        loadUse_s  = 1'b0;
        memStall_s = 1'b0;
        stallF_s   = 1'b0;
        stallD_s   = 1'b0;
        stallE_s   = 1'b0;
        stallM_s   = 1'b0;
        flushD_s   = 1'b0;
        flushE_s   = 1'b0;
        flushW_s   = 1'b0;
        case (state_r)
            RUN: begin
                memStall_s = MemReqM_i && !MemReadyM_i;
                loadUse_s  = (ResultSrcE_i == 2'b01) && (RdE_i != REG_ZERO) &&
                             ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
            end
            MEM_WAIT: begin
                memStall_s = 1'b1;
            end
            ERROR: begin
                memStall_s = 1'b1;
            end
            default: begin
                memStall_s = 1'b1;
            end
        endcase
        // A frozen pipeline holds any pending branch; it is applied once the stall lifts.
        if (!rst_n_i) begin
            stallF_s = 1'b0;
        end else if (memStall_s) begin
            stallF_s = 1'b1;
            stallD_s = 1'b1;
            stallE_s = 1'b1;
            stallM_s = 1'b1;
            flushW_s = 1'b1;
        end else if (PCSrcE_i) begin
            flushD_s = 1'b1;
            flushE_s = 1'b1;
        end else if (loadUse_s) begin
            stallF_s = 1'b1;
            stallD_s = 1'b1;
            flushE_s = 1'b1;
        end else begin
            stallF_s = 1'b0;
        end
    end

    assign StallF_o     = stallF_s;
    assign StallD_o     = stallD_s;
    assign StallE_o     = stallE_s;
    assign StallM_o     = stallM_s;
    assign FlushD_o     = flushD_s;
    assign FlushE_o     = flushE_s;
    assign FlushW_o     = flushW_s;
    assign MemTimeout_o = (state_r == ERROR);

`ifdef HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] stallCnt_r;

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stallCnt_r <= {CNT_WIDTH{1'b0}};
        end else if (stallF_s && (stallCnt_r != {CNT_WIDTH{1'b1}})) begin
            stallCnt_r <= stallCnt_r + CNT_WIDTH'(1);
        end else begin
            stallCnt_r <= stallCnt_r;
        end
    end

    assign StallCount_o = stallCnt_r;
`else
    assign StallCount_o = {CNT_WIDTH{1'b0}};
`endif

endmodule
